esl_axis_interface: RTL and testbench
=====================================

ESL_AXIS_INTERFACE -- requirements
Module: esl_axis_interface

Interface
REQ-001 Parameter NUM_AXES, default 2: number of encoder/motor channels, legal range 1..8.
REQ-002 Parameter DATA_WIDTH, default 32: Avalon data and position counter width.
REQ-003 Parameter COUNT_SIZE, default 11: PWM period counter width; period is 2^COUNT_SIZE cycles.
REQ-004 Parameter DEADTIME, default 64: cycles of forced coast on direction change.
REQ-005 clk  in  1  sole clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 slave_address  in  8  Avalon-MM word address.
REQ-008 slave_read / slave_write  in  1 each  Avalon-MM strobes.
REQ-009 slave_writedata  in  DATA_WIDTH; slave_byteenable  in  DATA_WIDTH/8  per-byte write mask.
REQ-010 slave_readdata  out  DATA_WIDTH  registered read data.
REQ-011 ENC_A, ENC_B  in  NUM_AXES each  asynchronous quadrature inputs, bit i = axis i.
REQ-012 PWM_VAL, DIRA, DIRB  out  NUM_AXES each  H-bridge drive, bit i = axis i.

Function
REQ-013 Register map: 0x00 GLOBAL_CTRL (bit31 soft-reset all counters, bit0 snapshot strobe); 0x01 STATUS (bit i = axis i encoder-error, sticky, write-1-to-clear); axis i base 0x04+4i: +0 AXIS_CTRL (bit31 axis soft reset, bit30 dir, bit29 enable, [COUNT_SIZE-1:0] duty), +1 POSITION, +2 SNAPSHOT, +3 VELOCITY.
REQ-014 Read latency exactly one cycle; unmapped addresses read 0; writes to POSITION/SNAPSHOT/VELOCITY and unmapped addresses are ignored.
REQ-015 Writes honour slave_byteenable per byte; GLOBAL_CTRL bits 31 and 0 self-clear one cycle after being written.
REQ-016 Read and write to the same address in one cycle: read returns the pre-write value.
REQ-017 Encoder inputs pass a 2-FF synchroniser; x4 decoding; A-leads-B increments, B-leads-A decrements.
REQ-018 Both synchronised inputs changing in one cycle: no count change, STATUS bit i set.
REQ-019 POSITION wraps two's-complement at DATA_WIDTH bits, no saturation.
REQ-020 Axis or global soft reset clears POSITION the cycle after the write; reset wins over a simultaneous count.
REQ-021 Snapshot strobe copies all POSITION values into SNAPSHOT in the same cycle, including any count occurring that cycle.
REQ-022 PWM: free-running COUNT_SIZE-bit counter per axis; PWM_VAL high while counter < duty; duty 0 = always low, duty all-ones = low one cycle per period.
REQ-023 Enable=0: PWM_VAL, DIRA, DIRB all 0 (coast). Enable=1: DIRA=dir, DIRB=~dir.
REQ-024 Per-axis FSM RUN/DEAD: RUN->DEAD when dir bit changes while enabled; DEAD drives all outputs 0 for DEADTIME cycles, then DEAD->RUN with new dir; dir change during DEAD restarts the count.
REQ-025 Axis soft reset also clears that axis's PWM counter and returns the FSM to RUN.

Reset
REQ-026 reset clears all registers, counters, synchronisers, STATUS and slave_readdata to 0; FSMs enter RUN; outputs 0 from the cycle after reset asserts.

Configuration
REQ-027 Macro ESL_AXIS_VELOCITY_EN defined: per axis, VELOCITY latches signed POSITION delta over each VEL_WINDOW (package constant, 2^16 cycles) window, updated on window end.
REQ-028 Macro undefined: no velocity logic; VELOCITY offsets read 0.

Structure
REQ-029 Package esl_axis_pkg holds register offsets, bit positions, axis stride 4, VEL_WINDOW, and the FSM state encoding.
REQ-030 Sub-module esl_axis_channel holds one axis's synchroniser, decoder, PWM, and dead-time FSM; top instantiates NUM_AXES copies and the register file.

Verification
REQ-031 A-leading quadrature, 10 full cycles on axis 0 -> POSITION(0x05) reads 40; reversed phase then reads 0.
REQ-032 Both inputs toggled in one cycle -> POSITION unchanged, STATUS=0x1; write 0x1 to STATUS -> reads 0.
REQ-033 Enable, duty=512, COUNT_SIZE=11 -> PWM_VAL high 512 of 2048 cycles; flip dir -> all outputs 0 for 64 cycles, then DIRA/DIRB swapped.
REQ-034 POSITION at 0xFFFFFFFF plus one increment -> 0x00000000; snapshot strobe on a count cycle -> SNAPSHOT equals post-count POSITION.
REQ-035 Byteenable=0x1 write of 0xFFFFFFFF to AXIS_CTRL -> reads 0x000000FF; reset mid-DEAD -> all outputs 0, FSM RUN.
REQ-036 With ESL_AXIS_VELOCITY_EN, 100 counts in one window -> VELOCITY reads 100 after window end; without macro reads 0.

Source files
------------

// File: rtl/esl_axis_pkg.sv
// esl_axis_pkg: register map, bit positions, velocity window and channel FSM encoding.
// Shared by the register file, the per-axis channel and any software-facing model.
package esl_axis_pkg;

   localparam int ADDR_GLOBAL_CTRL = 8'h00;
   localparam int ADDR_STATUS      = 8'h01;
   localparam int AXIS_BASE        = 8'h04;
   localparam int AXIS_STRIDE      = 4;

   localparam int OFF_CTRL     = 0;
   localparam int OFF_POSITION = 1;
   localparam int OFF_SNAPSHOT = 2;
   localparam int OFF_VELOCITY = 3;

   localparam int BIT_SOFT_RST = 31;
   localparam int BIT_DIR      = 30;
   localparam int BIT_ENABLE   = 29;
   localparam int BIT_SNAPSHOT = 0;

   localparam int VEL_WINDOW = 65536;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DEAD = 1'b1
   } axis_state_t;

   function automatic logic [7:0] axis_reg_addr(input int axis, input int off);
      return 8'(AXIS_BASE + AXIS_STRIDE * axis + off);
   endfunction

endpackage

// File: rtl/esl_axis_if.sv
// esl_axis_if: Avalon-MM slave bus bundle for the axis controller.
// Latency: readdata valid one cycle after read; backpressure: none (no waitrequest).
interface esl_axis_if #(
   parameter int DATA_WIDTH = 32
);
   logic [7:0]              slave_address;
   logic                    slave_read;
   logic                    slave_write;
   logic [DATA_WIDTH-1:0]   slave_writedata;
   logic [DATA_WIDTH/8-1:0] slave_byteenable;
   logic [DATA_WIDTH-1:0]   slave_readdata;

   modport master (
      output slave_address, slave_read, slave_write, slave_writedata, slave_byteenable,
      input  slave_readdata
   );

   modport slave (
      input  slave_address, slave_read, slave_write, slave_writedata, slave_byteenable,
      output slave_readdata
   );
endinterface

// File: rtl/esl_axis_channel.sv
// esl_axis_channel: one axis -- encoder sync + x4 decode, PWM generator, RUN/DEAD direction FSM.
// Latency: count pulse 2 cycles after an input edge, drive outputs registered; backpressure: none.
module esl_axis_channel
   import esl_axis_pkg::*;
#(
   parameter int COUNT_SIZE = 11,
   parameter int DEADTIME   = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enc_a,
   input  logic                  enc_b,
   input  logic                  enable,
   input  logic                  dir,
   input  logic [COUNT_SIZE-1:0] duty,
   input  logic                  axis_srst,
   input  logic                  cnt_clr,
   output logic                  count_up,
   output logic                  count_dn,
   output logic                  enc_err,
   output logic                  pwm_val,
   output logic                  dira,
   output logic                  dirb
);
   localparam int DCW = $clog2(DEADTIME + 1);
   localparam logic [DCW-1:0] DEAD_LAST = DCW'(DEADTIME - 1);

   logic [1:0]            a_sync, b_sync;
   logic                  a_prev, b_prev, a_chg, b_chg;
   logic [COUNT_SIZE-1:0] pwm_cnt;
   logic                  pwm_raw;
   axis_state_t           state;
   logic [DCW-1:0]        dead_cnt;
   logic                  dir_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         a_sync <= '0;
         b_sync <= '0;
         a_prev <= 1'b0;
         b_prev <= 1'b0;
      end else begin
         a_sync <= {a_sync[0], enc_a};
         b_sync <= {b_sync[0], enc_b};
         a_prev <= a_sync[1];
         b_prev <= b_sync[1];
      end
   end

   assign a_chg = a_sync[1] ^ a_prev;
   assign b_chg = b_sync[1] ^ b_prev;

   // An A edge that leaves A!=B, or a B edge that leaves A==B, is forward motion.
   always_comb begin
      count_up = 1'b0;
      count_dn = 1'b0;
      enc_err  = a_chg & b_chg;
      if (a_chg && !b_chg) begin
         count_up = a_sync[1] ^ b_sync[1];
         count_dn = ~(a_sync[1] ^ b_sync[1]);
      end else if (b_chg && !a_chg) begin
         count_up = ~(a_sync[1] ^ b_sync[1]);
         count_dn = a_sync[1] ^ b_sync[1];
      end
   end

   always_ff @(posedge clk) begin
      if (reset || cnt_clr) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
      end
   end

   assign pwm_raw = (pwm_cnt < duty);

   always_ff @(posedge clk) begin
      if (reset) begin
         dir_q <= 1'b0;
      end else begin
         dir_q <= dir;
      end
   end

   // Leaving DEAD drives the new direction on the same edge so the coast lasts exactly DEADTIME.
   always_ff @(posedge clk) begin
      if (reset || axis_srst) begin
         state    <= ST_RUN;
         dead_cnt <= '0;
         pwm_val  <= 1'b0;
         dira     <= 1'b0;
         dirb     <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (enable && (dir != dir_q)) begin
                  state    <= ST_DEAD;
                  dead_cnt <= '0;
                  pwm_val  <= 1'b0;
                  dira     <= 1'b0;
                  dirb     <= 1'b0;
               end else begin
                  pwm_val <= enable & pwm_raw;
                  dira    <= enable & dir;
                  dirb    <= enable & ~dir;
               end
            end
            default: begin
               pwm_val <= 1'b0;
               dira    <= 1'b0;
               dirb    <= 1'b0;
               if (dir != dir_q) begin
                  dead_cnt <= '0;
               end else if (dead_cnt == DEAD_LAST) begin
                  state   <= ST_RUN;
                  pwm_val <= enable & pwm_raw;
                  dira    <= enable & dir;
                  dirb    <= enable & ~dir;
               end else begin
                  dead_cnt <= dead_cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/esl_axis_interface.sv
// esl_axis_interface: Avalon-MM register file over NUM_AXES encoder/PWM channels; ESL_AXIS_VELOCITY_EN adds VELOCITY.
// Latency: 1-cycle registered read, writes take effect next cycle; backpressure: none, bus always accepted.
module esl_axis_interface
   import esl_axis_pkg::*;
#(
   parameter int NUM_AXES   = 2,
   parameter int DATA_WIDTH = 32,
   parameter int COUNT_SIZE = 11,
   parameter int DEADTIME   = 64
) (
   input  logic                clk,
   input  logic                reset,
   esl_axis_if.slave           bus,
   input  logic [NUM_AXES-1:0] ENC_A,
   input  logic [NUM_AXES-1:0] ENC_B,
   output logic [NUM_AXES-1:0] PWM_VAL,
   output logic [NUM_AXES-1:0] DIRA,
   output logic [NUM_AXES-1:0] DIRB
);
   localparam int NBYTES = DATA_WIDTH / 8;
   typedef logic [DATA_WIDTH-1:0] word_t;

   word_t                 wmask, wdata_m, glob_rd, glob_new, rd_val;
   word_t                 ctrl_rd  [NUM_AXES];
   word_t                 ctrl_new [NUM_AXES];
   word_t                 position [NUM_AXES];
   word_t                 pos_next [NUM_AXES];
   word_t                 snapshot [NUM_AXES];
   word_t                 velocity [NUM_AXES];
   logic [COUNT_SIZE-1:0] ax_duty  [NUM_AXES];
   logic [NUM_AXES-1:0]   ax_srst, ax_dir, ax_en, wr_axis, status, status_clr;
   logic [NUM_AXES-1:0]   cnt_up, cnt_dn, enc_err;
   logic                  glob_srst, glob_snap, wr_glob, wr_status;
   logic                  unused_bits;

   always_comb begin
      wmask = '0;
      for (int b = 0; b < NBYTES; b++) begin
         wmask[b*8 +: 8] = {8{bus.slave_byteenable[b]}};
      end
      wdata_m   = bus.slave_writedata & wmask;
      wr_glob   = bus.slave_write && (bus.slave_address == 8'(ADDR_GLOBAL_CTRL));
      wr_status = bus.slave_write && (bus.slave_address == 8'(ADDR_STATUS));
      status_clr = wr_status ? wdata_m[NUM_AXES-1:0] : '0;

      glob_rd               = '0;
      glob_rd[BIT_SOFT_RST] = glob_srst;
      glob_rd[BIT_SNAPSHOT] = glob_snap;
      glob_new              = (glob_rd & ~wmask) | wdata_m;
      unused_bits           = ^glob_new;

      for (int i = 0; i < NUM_AXES; i++) begin
         ctrl_rd[i]                   = '0;
         ctrl_rd[i][BIT_SOFT_RST]     = ax_srst[i];
         ctrl_rd[i][BIT_DIR]          = ax_dir[i];
         ctrl_rd[i][BIT_ENABLE]       = ax_en[i];
         ctrl_rd[i][COUNT_SIZE-1:0]   = ax_duty[i];
         ctrl_new[i]                  = (ctrl_rd[i] & ~wmask) | wdata_m;
         wr_axis[i]  = bus.slave_write && (bus.slave_address == axis_reg_addr(i, OFF_CTRL));
         unused_bits = unused_bits ^ (^ctrl_new[i]);
      end
   end

   // Soft-reset and snapshot bits are one-cycle pulses: they hold only on the cycle after a write.
   always_ff @(posedge clk) begin
      if (reset) begin
         glob_srst <= 1'b0;
         glob_snap <= 1'b0;
         status    <= '0;
         ax_srst   <= '0;
         ax_dir    <= '0;
         ax_en     <= '0;
         for (int i = 0; i < NUM_AXES; i++) ax_duty[i] <= '0;
      end else begin
         glob_srst <= wr_glob & glob_new[BIT_SOFT_RST];
         glob_snap <= wr_glob & glob_new[BIT_SNAPSHOT];
         status    <= (status & ~status_clr) | enc_err;
         for (int i = 0; i < NUM_AXES; i++) begin
            ax_srst[i] <= wr_axis[i] & ctrl_new[i][BIT_SOFT_RST];
            if (wr_axis[i]) begin
               ax_dir[i]  <= ctrl_new[i][BIT_DIR];
               ax_en[i]   <= ctrl_new[i][BIT_ENABLE];
               ax_duty[i] <= ctrl_new[i][COUNT_SIZE-1:0];
            end
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_AXES; i++) begin
         pos_next[i] = position[i];
         if (glob_srst || ax_srst[i]) begin
            pos_next[i] = '0;
         end else if (cnt_up[i]) begin
            pos_next[i] = position[i] + word_t'(1);
         end else if (cnt_dn[i]) begin
            pos_next[i] = position[i] - word_t'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_AXES; i++) begin
            position[i] <= '0;
            snapshot[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_AXES; i++) begin
            position[i] <= pos_next[i];
            if (glob_snap) snapshot[i] <= pos_next[i];
         end
      end
   end

`ifdef ESL_AXIS_VELOCITY_EN
   localparam int VW = $clog2(VEL_WINDOW);
   logic [VW-1:0] win_cnt;
   word_t         vel_base [NUM_AXES];

   always_ff @(posedge clk) begin
      if (reset) begin
         win_cnt <= '0;
         for (int i = 0; i < NUM_AXES; i++) begin
            vel_base[i] <= '0;
            velocity[i] <= '0;
         end
      end else begin
         win_cnt <= win_cnt + 1'b1;
         if (win_cnt == VW'(VEL_WINDOW - 1)) begin
            for (int i = 0; i < NUM_AXES; i++) begin
               velocity[i] <= pos_next[i] - vel_base[i];
               vel_base[i] <= pos_next[i];
            end
         end
      end
   end
`else
   always_comb begin
      for (int i = 0; i < NUM_AXES; i++) velocity[i] = '0;
   end
`endif

   always_comb begin
      rd_val = '0;
      if (bus.slave_address == 8'(ADDR_GLOBAL_CTRL)) rd_val = glob_rd;
      if (bus.slave_address == 8'(ADDR_STATUS))      rd_val = word_t'(status);
      for (int i = 0; i < NUM_AXES; i++) begin
         if (bus.slave_address == axis_reg_addr(i, OFF_CTRL))     rd_val = ctrl_rd[i];
         if (bus.slave_address == axis_reg_addr(i, OFF_POSITION)) rd_val = position[i];
         if (bus.slave_address == axis_reg_addr(i, OFF_SNAPSHOT)) rd_val = snapshot[i];
         if (bus.slave_address == axis_reg_addr(i, OFF_VELOCITY)) rd_val = velocity[i];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus.slave_readdata <= '0;
      end else if (bus.slave_read) begin
         bus.slave_readdata <= rd_val;
      end
   end

   for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
      esl_axis_channel #(
         .COUNT_SIZE (COUNT_SIZE),
         .DEADTIME   (DEADTIME)
      ) u_channel (
         .clk       (clk),
         .reset     (reset),
         .enc_a     (ENC_A[i]),
         .enc_b     (ENC_B[i]),
         .enable    (ax_en[i]),
         .dir       (ax_dir[i]),
         .duty      (ax_duty[i]),
         .axis_srst (ax_srst[i]),
         .cnt_clr   (ax_srst[i] | glob_srst),
         .count_up  (cnt_up[i]),
         .count_dn  (cnt_dn[i]),
         .enc_err   (enc_err[i]),
         .pwm_val   (PWM_VAL[i]),
         .dira      (DIRA[i]),
         .dirb      (DIRB[i])
      );
   end

endmodule

// File: tb/tb_esl_axis_interface.sv
// tb_esl_axis_interface: random quadrature traffic against a position model, plus PWM/dead-time/register-map checks.
module tb_esl_axis_interface;
   import esl_axis_pkg::*;

   localparam int NA = 2;
   localparam int DW = 32;
   localparam int CS = 11;
   localparam int DT = 64;

   logic          clk = 1'b0;
   logic          reset;
   logic [NA-1:0] enc_a, enc_b, pwm_val, dira, dirb;

   esl_axis_if #(.DATA_WIDTH(DW)) bus ();

   esl_axis_interface #(
      .NUM_AXES   (NA),
      .DATA_WIDTH (DW),
      .COUNT_SIZE (CS),
      .DEADTIME   (DT)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .ENC_A   (enc_a),
      .ENC_B   (enc_b),
      .PWM_VAL (pwm_val),
      .DIRA    (dira),
      .DIRB    (dirb)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] m_pos [NA];
   int          phase [NA];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
      @(negedge clk);
      bus.slave_address    = a;
      bus.slave_writedata  = d;
      bus.slave_byteenable = be;
      bus.slave_write      = 1'b1;
      @(negedge clk);
      bus.slave_write      = 1'b0;
      bus.slave_byteenable = '0;
   endtask

   task automatic check_reg(input string tag, input logic [7:0] a, input logic [31:0] exp);
      @(negedge clk);
      bus.slave_address = a;
      bus.slave_read    = 1'b1;
      @(negedge clk);
      bus.slave_read    = 1'b0;
      chk(tag, bus.slave_readdata, exp);
   endtask

   // Gray sequence (A,B): 00 -> 10 -> 11 -> 01; stepping forward means A leads B.
   task automatic drive_enc();
      for (int i = 0; i < NA; i++) begin
         enc_a[i] = (phase[i] == 1) || (phase[i] == 2);
         enc_b[i] = (phase[i] >= 2);
      end
   endtask

   task automatic enc_step(input int ax, input int dirn);
      @(negedge clk);
      phase[ax] = (phase[ax] + 4 + dirn) % 4;
      drive_enc();
      m_pos[ax] = m_pos[ax] + 32'(dirn);
      repeat (3) @(negedge clk);
   endtask

   task automatic enc_glitch(input int ax);
      @(negedge clk);
      phase[ax] = (phase[ax] + 2) % 4;
      drive_enc();
      repeat (3) @(negedge clk);
   endtask

   task automatic count_pwm_high(input int ax, output int hi);
      hi = 0;
      repeat (1 << CS) begin
         @(negedge clk);
         if (pwm_val[ax]) hi++;
      end
   endtask

   initial begin
      int hi, n, ax, d;
      logic seen;
      reset = 1'b1;
      bus.slave_address = '0; bus.slave_read = 1'b0; bus.slave_write = 1'b0;
      bus.slave_writedata = '0; bus.slave_byteenable = '0;
      enc_a = '0; enc_b = '0;
      for (int i = 0; i < NA; i++) begin m_pos[i] = '0; phase[i] = 0; end
      repeat (3) @(negedge clk);
      chk("rst_readdata", bus.slave_readdata, 32'h0);
      chk("rst_outputs", 32'({pwm_val, dira, dirb}), 32'h0);
      reset = 1'b0;
      check_reg("rst_status", 8'h01, 32'h0);
      check_reg("rst_pos0", 8'h05, 32'h0);
      check_reg("rst_ctrl1", 8'h08, 32'h0);

`ifdef ESL_AXIS_VELOCITY_EN
      repeat (100) enc_step(0, 1);
      repeat (VEL_WINDOW) @(negedge clk);
      check_reg("velocity_100", 8'h07, 32'd100);
`else
      repeat (10) enc_step(0, 1);
      check_reg("velocity_off", 8'h07, 32'h0);
`endif

      repeat (40) enc_step(0, 1);
      check_reg("fwd_40", 8'h05, m_pos[0]);
      repeat (40) enc_step(0, -1);
      check_reg("rev_40", 8'h05, m_pos[0]);

      for (int r = 0; r < 3; r++) begin
         repeat (15) begin
            ax = $urandom_range(0, NA - 1);
            d  = ($urandom_range(0, 1) == 1) ? 1 : -1;
            n  = $urandom_range(1, 6);
            repeat (n) enc_step(ax, d);
         end
         check_reg("rand_pos0", 8'h05, m_pos[0]);
         check_reg("rand_pos1", 8'h09, m_pos[1]);
      end

      enc_glitch(0);
      check_reg("glitch_pos0", 8'h05, m_pos[0]);
      check_reg("glitch_status0", 8'h01, 32'h1);
      bus_write(8'h01, 32'h1, 4'hF);
      check_reg("status_w1c0", 8'h01, 32'h0);
      enc_glitch(1);
      bus_write(8'h01, 32'h1, 4'hF);
      check_reg("status_w1c_other", 8'h01, 32'h2);
      bus_write(8'h01, 32'h2, 4'hF);
      check_reg("status_w1c1", 8'h01, 32'h0);

      bus_write(8'h08, 32'h8000_0000, 4'hF);
      m_pos[1] = '0;
      repeat (3) @(negedge clk);
      check_reg("axis_srst_pos1", 8'h09, m_pos[1]);
      enc_step(1, -1);
      check_reg("wrap_neg", 8'h09, 32'hFFFF_FFFF);
      enc_step(1, 1);
      check_reg("wrap_zero", 8'h09, 32'h0);

      // Strobe lands on the cycle the synchronised edge is counted.
      @(negedge clk);
      phase[0] = (phase[0] + 1) % 4;
      drive_enc();
      m_pos[0] = m_pos[0] + 32'd1;
      @(negedge clk);
      bus.slave_address = 8'h00; bus.slave_writedata = 32'h1;
      bus.slave_byteenable = 4'hF; bus.slave_write = 1'b1;
      @(negedge clk);
      bus.slave_write = 1'b0;
      repeat (3) @(negedge clk);
      check_reg("snap_pos0", 8'h06, m_pos[0]);
      check_reg("snap_pos1", 8'h0A, m_pos[1]);
      check_reg("pos0_after_snap", 8'h05, m_pos[0]);

      bus_write(8'h00, 32'h8000_0001, 4'hF);
      for (int i = 0; i < NA; i++) m_pos[i] = '0;
      repeat (3) @(negedge clk);
      check_reg("glob_selfclear", 8'h00, 32'h0);
      check_reg("glob_srst_pos0", 8'h05, m_pos[0]);
      check_reg("glob_srst_snap0", 8'h06, 32'h0);

      bus_write(8'h04, 32'h2000_0200, 4'hF);
      repeat (4) @(negedge clk);
      count_pwm_high(0, hi);
      chk("pwm_512", 32'(hi), 32'd512);
      chk("run_dir0", 32'({dira[0], dirb[0]}), 32'b01);

      bus_write(8'h04, 32'h6000_0200, 4'hF);
      n = 0;
      seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk);
         if (dira[0]) seen = 1'b1;
         else if (!pwm_val[0] && !dirb[0]) n++;
      end
      chk("dead_exit", 32'(seen), 32'h1);
      chk("deadtime", 32'(n), 32'(DT));
      chk("run_dir1", 32'({dira[0], dirb[0]}), 32'b10);
      check_reg("ctrl0_readback", 8'h04, 32'h6000_0200);

      bus_write(8'h04, 32'h6000_07FF, 4'hF);
      repeat (4) @(negedge clk);
      count_pwm_high(0, hi);
      chk("pwm_full_low", 32'((1 << CS) - hi), 32'd1);
      bus_write(8'h04, 32'h6000_0000, 4'hF);
      repeat (4) @(negedge clk);
      count_pwm_high(0, hi);
      chk("pwm_zero", 32'(hi), 32'd0);
      bus_write(8'h04, 32'h4000_0200, 4'hF);
      repeat (3) @(negedge clk);
      chk("disabled_coast", 32'({pwm_val[0], dira[0], dirb[0]}), 32'h0);

      bus_write(8'h08, 32'hFFFF_FFFF, 4'h1);
      check_reg("byteen_ctrl1", 8'h08, 32'h0000_00FF);
      @(negedge clk);
      bus.slave_address = 8'h08; bus.slave_writedata = 32'h0000_0123;
      bus.slave_byteenable = 4'hF; bus.slave_write = 1'b1; bus.slave_read = 1'b1;
      @(negedge clk);
      bus.slave_write = 1'b0; bus.slave_read = 1'b0;
      chk("rw_same_prewrite", bus.slave_readdata, 32'h0000_00FF);
      check_reg("rw_same_after", 8'h08, 32'h0000_0123);

      check_reg("unmapped_02", 8'h02, 32'h0);
      check_reg("unmapped_axis2", 8'h0C, 32'h0);
      check_reg("unmapped_ff", 8'hFF, 32'h0);
      enc_step(0, 1);
      bus_write(8'h05, 32'h1234_5678, 4'hF);
      check_reg("pos_write_ignored", 8'h05, m_pos[0]);

      bus_write(8'h04, 32'h2000_0100, 4'hF);
      repeat (5) @(negedge clk);
      bus_write(8'h04, 32'h6000_0100, 4'hF);
      repeat (10) @(negedge clk);
      chk("in_dead", 32'({pwm_val[0], dira[0], dirb[0]}), 32'h0);
      enc_a = '0; enc_b = '0;
      reset = 1'b1;
      @(negedge clk);
      chk("reset_dead_outputs", 32'({pwm_val, dira, dirb}), 32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check_reg("reset_ctrl0", 8'h04, 32'h0);
      bus_write(8'h04, 32'h2000_0100, 4'hF);
      repeat (3) @(negedge clk);
      chk("reset_fsm_run", 32'({dira[0], dirb[0]}), 32'b01);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
      $fatal(1, "timeout");
   end

endmodule
